// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, reads instructions from Memory with a fixed latency and hands them to decode.
// Defining FETCH_PERF_EN adds the fetchCount accepted-instruction counter port.
module fetch_unit #(
    parameter int n = 64,
    parameter int memLatency = 1,
    parameter logic [n-1:0] resetPC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic [n-1:0] memAddress,
    output logic         memRead,
    input  logic [n-1:0] memData,
    output logic [n-1:0] instr,
    output logic [n-1:0] instrPC,
    output logic         instrValid,
    input  logic         instrReady,
    input  logic         branchTaken,
    input  logic [n-1:0] branchTarget
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  fetchCount
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, VALID} state_t;

    state_t state, state_nxt;
    logic [n-1:0] pc;
    logic [3:0] cnt;
    logic redirect, capture, accept;

    assign memAddress = pc;
    assign memRead = (state == FETCH) || (state == WAIT);
    assign instrValid = state == VALID;
    assign redirect = branchTaken && (state != IDLE);
    // a redirect on the final wait edge abandons the read instead of capturing it
    assign capture = (state == WAIT) && (cnt == 4'd1) && !redirect;
    assign accept = instrValid && instrReady;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = (cnt == 4'd1) ? VALID : WAIT;
            default: state_nxt = instrReady ? FETCH : VALID;
        endcase
        if (redirect) state_nxt = FETCH;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= resetPC;
            cnt <= '0;
            instr <= '0;
            instrPC <= '0;
        end else begin
            cnt <= (state == FETCH) ? 4'(memLatency) : (state == WAIT) ? cnt - 4'd1 : cnt;
            pc <= redirect ? (branchTarget & {{(n-2){1'b1}}, 2'b00})
                : capture ? pc + {{(n-3){1'b0}}, 3'd4} : pc;
            if (capture) begin
                instr <= memData;
                instrPC <= pc;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fetchCount <= '0;
        else if (accept) fetchCount <= fetchCount + 32'd1;
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; DUT a (latency 1, resetPC 0) takes backpressure, branches and reset,
// DUT b (latency 3, resetPC at the top of the address space) checks wrap-around and throughput.
module tb_fetch_unit;
    localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;
    localparam logic [63:0] NONE = 64'hDEAD_DEAD_DEAD_DEAD;

    logic clk = 1'b0;
    logic rst_a, rst_b, rdy_a, rdy_b, br_a;
    logic [63:0] tgt_a;
    logic [63:0] a_addr, a_data, a_ins, a_ipc, b_addr, b_data, b_ins, b_ipc, b_p0, b_p1;
    logic a_rd, a_v, b_rd, b_v;
    logic a_prd = 1'b0, b_prd = 1'b0;
    logic [63:0] a_paddr = '0, b_paddr = '0;
`ifdef FETCH_PERF_EN
    logic [31:0] a_fc, b_fc;
`endif
    int n_tests = 0, n_fail = 0;
    logic [63:0] a_fq[$], b_fq[$];
    logic [127:0] a_iq[$], b_iq[$];

    fetch_unit #(.n(64), .memLatency(1), .resetPC(64'h0)) dut_a (
        .clk(clk), .reset(rst_a), .memAddress(a_addr), .memRead(a_rd), .memData(a_data),
        .instr(a_ins), .instrPC(a_ipc), .instrValid(a_v), .instrReady(rdy_a),
        .branchTaken(br_a), .branchTarget(tgt_a)
`ifdef FETCH_PERF_EN
        , .fetchCount(a_fc)
`endif
    );

    fetch_unit #(.n(64), .memLatency(3), .resetPC(64'hFFFF_FFFF_FFFF_FFFC)) dut_b (
        .clk(clk), .reset(rst_b), .memAddress(b_addr), .memRead(b_rd), .memData(b_data),
        .instr(b_ins), .instrPC(b_ipc), .instrValid(b_v), .instrReady(rdy_b),
        .branchTaken(1'b0), .branchTarget(64'h0)
`ifdef FETCH_PERF_EN
        , .fetchCount(b_fc)
`endif
    );

    initial forever #5 clk = ~clk;

    function automatic logic [63:0] mem(input logic [63:0] a);
        return {2'b00, a[63:2]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_a(input logic [63:0] pc, input bit inst);
        a_fq.push_back(pc);
        if (inst) a_iq.push_back({pc, mem(pc)});
    endtask

    task automatic push_b(input logic [63:0] pc, input bit inst);
        b_fq.push_back(pc);
        if (inst) b_iq.push_back({pc, mem(pc)});
    endtask

    // memory models: data returns memLatency cycles after the request cycle, junk when not reading
    always @(posedge clk) begin
        a_data <= a_rd ? mem(a_addr) : JUNK;
        b_p0 <= b_rd ? mem(b_addr) : JUNK;
        b_p1 <= b_p0;
        b_data <= b_p1;
    end

    always @(negedge clk) begin
        logic [127:0] e;
        if (a_rd && (!a_prd || a_addr != a_paddr)) begin
            if (a_fq.size() != 0) chk("a_fetch_addr", a_addr, a_fq.pop_front());
            else chk("a_fetch_addr", a_addr, NONE);
        end
        if (a_v && rdy_a) begin
            e = (a_iq.size() != 0) ? a_iq.pop_front() : {NONE, NONE};
            chk("a_instrPC", a_ipc, e[127:64]);
            chk("a_instr", a_ins, e[63:0]);
        end
        a_prd <= a_rd;
        a_paddr <= a_addr;
    end

    always @(negedge clk) begin
        logic [127:0] e;
        if (b_rd && (!b_prd || b_addr != b_paddr)) begin
            if (b_fq.size() != 0) chk("b_fetch_addr", b_addr, b_fq.pop_front());
            else chk("b_fetch_addr", b_addr, NONE);
        end
        if (b_v && rdy_b) begin
            e = (b_iq.size() != 0) ? b_iq.pop_front() : {NONE, NONE};
            chk("b_instrPC", b_ipc, e[127:64]);
            chk("b_instr", b_ins, e[63:0]);
        end
        b_prd <= b_rd;
        b_paddr <= b_addr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1; br_a = 1'b0; tgt_a = '0;
        fork
            begin
                @(negedge clk);
                chk("a_rst_addr", a_addr, 64'h0);
                chk("a_rst_rd", a_rd, 0);
                chk("a_rst_valid", a_v, 0);
                chk("a_rst_instr", a_ins, 0);
                chk("a_rst_pc", a_ipc, 0);
`ifdef FETCH_PERF_EN
                chk("a_rst_fc", a_fc, 0);
`endif
                for (int i = 0; i < 4; i++) push_a(64'(4 * i), 1'b1);
                @(posedge clk); #1 rst_a = 1'b1;
                for (int k = 1; k <= 13; k++) begin
                    @(negedge clk);
                    chk($sformatf("a_rd_c%0d", k), a_rd, 64'(k % 3 != 1));
                    chk($sformatf("a_valid_c%0d", k), a_v, 64'(k >= 4 && k % 3 == 1));
                end
`ifdef FETCH_PERF_EN
                chk("a_fc_seq", a_fc, 3);
`endif
                @(posedge clk); #1 rdy_a = 1'b0;
                push_a(64'd16, 1'b1);
                for (int i = 0; i < 10 && !a_v; i++) @(negedge clk);
                chk("a_bp_valid", a_v, 1);
                for (int j = 0; j < 5; j++) begin
                    chk("a_bp_instr", a_ins, 64'd4);
                    chk("a_bp_pc", a_ipc, 64'd16);
                    chk("a_bp_rd", a_rd, 0);
                    chk("a_bp_hold", a_v, 1);
                    @(negedge clk);
                end
`ifdef FETCH_PERF_EN
                chk("a_fc_bp", a_fc, 4);
`endif
                @(posedge clk); #1 rdy_a = 1'b1;
                push_a(64'd20, 1'b0);
                @(negedge clk); @(negedge clk);
                chk("a_bp_next_rd", a_rd, 1);
                chk("a_bp_next_addr", a_addr, 64'd20);
                @(posedge clk); #1 br_a = 1'b1; tgt_a = 64'h103;
                push_a(64'h100, 1'b1);
                @(posedge clk); #1 br_a = 1'b0;
                @(negedge clk);
                chk("a_br_rd", a_rd, 1);
                chk("a_br_addr", a_addr, 64'h100);
                chk("a_br_novalid", a_v, 0);
                push_a(64'h104, 1'b0);
                for (int i = 0; i < 20 && !(a_rd && a_addr == 64'h104); i++) @(negedge clk);
                chk("a_wait_104", 64'(a_rd && a_addr == 64'h104), 1);
`ifdef FETCH_PERF_EN
                chk("a_fc_prerst", a_fc, 6);
`endif
                @(posedge clk); #2;
                chk("a_prerst_rd", a_rd, 1);
                #1 rst_a = 1'b0;
                #1;
                chk("a_mid_addr", a_addr, 64'h0);
                chk("a_mid_rd", a_rd, 0);
                chk("a_mid_valid", a_v, 0);
                chk("a_mid_instr", a_ins, 0);
                chk("a_mid_pc", a_ipc, 0);
`ifdef FETCH_PERF_EN
                chk("a_mid_fc", a_fc, 0);
`endif
                push_a(64'd0, 1'b1); push_a(64'd4, 1'b1); push_a(64'd8, 1'b1);
                push_a(64'h40, 1'b1); push_a(64'h44, 1'b0);
                @(posedge clk); #1 rst_a = 1'b1;
                @(negedge clk);
                chk("a_rr_idle", a_rd, 0);
                @(negedge clk);
                chk("a_rr_rd", a_rd, 1);
                chk("a_rr_addr", a_addr, 64'h0);
                for (int i = 0; i < 20 && !(a_v && a_ipc == 64'd8); i++) @(negedge clk);
                chk("a_find_8", 64'(a_v && a_ipc == 64'd8), 1);
`ifdef FETCH_PERF_EN
                chk("a_fc_pre_sim", a_fc, 2);
`endif
                #1 br_a = 1'b1; tgt_a = 64'h40;
                @(posedge clk); #1 br_a = 1'b0;
                @(negedge clk);
`ifdef FETCH_PERF_EN
                chk("a_fc_sim", a_fc, 3);
`endif
                chk("a_sim_rd", a_rd, 1);
                chk("a_sim_addr", a_addr, 64'h40);
                for (int i = 0; i < 10 && !a_v; i++) @(negedge clk);
                chk("a_sim_valid", a_v, 1);
                @(posedge clk); #1 rdy_a = 1'b0;
                repeat (3) @(negedge clk);
            end
            begin
                @(negedge clk);
                chk("b_rst_addr", b_addr, 64'hFFFF_FFFF_FFFF_FFFC);
                chk("b_rst_rd", b_rd, 0);
                chk("b_rst_valid", b_v, 0);
                push_b(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
                push_b(64'd0, 1'b1); push_b(64'd4, 1'b1); push_b(64'd8, 1'b0);
                @(posedge clk); #1 rst_b = 1'b1;
                for (int k = 1; k <= 16; k++) begin
                    @(negedge clk);
                    chk($sformatf("b_rd_c%0d", k), b_rd, 64'(k >= 2 && (k - 2) % 5 != 4));
                    chk($sformatf("b_valid_c%0d", k), b_v, 64'(k >= 2 && (k - 2) % 5 == 4));
                end
                @(posedge clk); #1 rdy_b = 1'b0;
                repeat (3) @(negedge clk);
`ifdef FETCH_PERF_EN
                chk("b_fc", b_fc, 3);
`endif
            end
        join
        chk("a_fetch_q_empty", 64'(a_fq.size()), 0);
        chk("a_instr_q_empty", 64'(a_iq.size()), 0);
        chk("b_fetch_q_empty", 64'(b_fq.size()), 0);
        chk("b_instr_q_empty", 64'(b_iq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
